// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter.
// A frame is loaded in raster order, filtered one pixel per cycle into a
// result buffer, then streamed out with valid/ready handshaking.
// Border pixels produce 0. Interior pixels produce either a binary threshold
// decision or the saturated gradient magnitude |gx| + |gy|.
module sobel_stream_filter #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [PIX_W+2:0]   threshold,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [PIX_W-1:0]   out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int MAG_W = PIX_W + 3;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int IDX_W = $clog2(NPIX);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] WIN_OFS  = IDX_W'(IMG_W + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROC,
    S_SEND,
    S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;        // load, process and send position (raster index)
  logic [IDX_W-1:0]   idx_next;
  logic [COL_W-1:0]   col;        // column of the pixel being processed
  logic [ROW_W-1:0]   row;        // row of the pixel being processed
  logic               mode_q;
  logic [MAG_W-1:0]   thr_q;

  logic [PIX_W-1:0]   in_buf  [0:NPIX-1];
  logic [PIX_W-1:0]   res_buf [0:NPIX-1];

  logic               in_fire;
  logic               out_fire;

  // Filter datapath signals
  logic               interior;
  logic [IDX_W-1:0]   win_base;
  logic [PIX_W-1:0]   win [0:2][0:2];
  logic [MAG_W-1:0]   sum_r, sum_l, sum_b, sum_t;
  logic [MAG_W-1:0]   diff_x, diff_y;
  logic [MAG_W-1:0]   abs_x, abs_y;
  logic [MAG_W-1:0]   mag;
  logic [PIX_W-1:0]   pix_res;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign idx_next = idx + IDX_ONE;

  // Input and result storage.
  // NOTE: the frame buffers are plain RAM with no reset; every frame fully
  // overwrites them before they are read, so clearing them would only cost logic.
  always_ff @(posedge clk) begin
    if (!reset && in_fire) begin
      in_buf[idx] <= in_data;
    end
    if (!reset && state == S_PROC) begin
      res_buf[idx] <= pix_res;
    end
  end

  // 3x3 window fetch around the current pixel; the top-left corner sits
  // IMG_W+1 positions before the centre. Border pixels never use the window,
  // so the base is parked at 0 to keep every read in range.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    interior = (row != '0) && (row != LAST_ROW) && (col != '0) && (col != LAST_COL);
    win_base = interior ? (idx - WIN_OFS) : '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[r][c] = in_buf[win_base + IDX_W'(r * IMG_W + c)];
      end
    end
  end

  // Sobel gradients and magnitude. The weighted column/row sums are at most
  // 4*(2^PIX_W-1), so MAG_W bits hold each sum, each difference in two's
  // complement, and the final |gx|+|gy| without overflow.
  always_comb begin
    sum_r = MAG_W'(win[0][2]) + (MAG_W'(win[1][2]) << 1) + MAG_W'(win[2][2]);
    sum_l = MAG_W'(win[0][0]) + (MAG_W'(win[1][0]) << 1) + MAG_W'(win[2][0]);
    sum_b = MAG_W'(win[2][0]) + (MAG_W'(win[2][1]) << 1) + MAG_W'(win[2][2]);
    sum_t = MAG_W'(win[0][0]) + (MAG_W'(win[0][1]) << 1) + MAG_W'(win[0][2]);
    diff_x = sum_r - sum_l;
    diff_y = sum_b - sum_t;
    abs_x  = diff_x[MAG_W-1] ? (~diff_x + MAG_W'(1)) : diff_x;
    abs_y  = diff_y[MAG_W-1] ? (~diff_y + MAG_W'(1)) : diff_y;
    mag    = abs_x + abs_y;
  end

  // Output pixel selection: border -> 0, else threshold or saturated magnitude.
  always_comb begin
    pix_res = '0;
    if (interior) begin
      if (mode_q) begin
        pix_res = (|mag[MAG_W-1:PIX_W]) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
      end else begin
        pix_res = (mag > thr_q) ? {PIX_W{1'b1}} : '0;
      end
    end
  end

  // Frame sequencer with registered handshake and status outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      col       <= '0;
      row       <= '0;
      mode_q    <= 1'b0;
      thr_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q   <= mode;
            thr_q    <= threshold;
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (in_fire) begin
            if (idx == LAST_IDX) begin
              idx      <= '0;
              col      <= '0;
              row      <= '0;
              in_ready <= 1'b0;
              state    <= S_PROC;
            end else begin
              idx <= idx_next;
            end
          end
        end

        S_PROC: begin
          if (col == LAST_COL) begin
            col <= '0;
            row <= row + ROW_ONE;
          end else begin
            col <= col + COL_ONE;
          end
          if (idx == LAST_IDX) begin
            // Result 0 was written on the first PROC cycle, so it is ready.
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= res_buf[0];
            state     <= S_SEND;
          end else begin
            idx <= idx_next;
          end
        end

        S_SEND: begin
          if (out_fire) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              idx      <= idx_next;
              out_data <= res_buf[idx_next];
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 Parameter IMG_W, default 16: frame width in pixels, >= 3.
REQ-002 Parameter IMG_H, default 16: frame height in pixels, >= 3.
REQ-003 Parameter PIX_W, default 8: pixel width in bits; MAG_W = PIX_W+3.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-007 mode  input  1  0 = binary threshold output, 1 = saturated magnitude output; sampled at accepted start.
REQ-008 threshold  input  MAG_W  binary threshold; sampled at accepted start.
REQ-009 in_valid  input  1  input pixel valid.
REQ-010 in_data  input  PIX_W  input pixel, unsigned, raster order.
REQ-011 in_ready  output  1  block accepts a pixel; high only in LOAD.
REQ-012 out_valid  output  1  output pixel valid; high only in SEND.
REQ-013 out_data  output  PIX_W  edge pixel, raster order.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the last output transfer.

Function
REQ-017 FSM states IDLE, LOAD, PROC, SEND, DONE; IDLE->LOAD on start, LOAD->PROC after the IMG_W*IMG_H-th accepted pixel, PROC->SEND after IMG_W*IMG_H cycles, SEND->DONE after the last transfer, DONE->IDLE unconditionally.
REQ-018 An input transfer occurs on in_valid && in_ready; pixel stored at raster index = transfer count; in_valid gaps stall LOAD without loss.
REQ-019 start in any state other than IDLE is ignored; mode/threshold changes after accepted start have no effect on the frame.
REQ-020 PROC computes exactly one pixel per cycle, indices 0..IMG_W*IMG_H-1, writing an internal result buffer.
REQ-021 Pixels on row 0, row IMG_H-1, column 0 or column IMG_W-1 produce out_data 0.
REQ-022 Interior: gx = (p[r-1][c+1]+2p[r][c+1]+p[r+1][c+1]) - (p[r-1][c-1]+2p[r][c-1]+p[r+1][c-1]); gy = same with rows r+1 minus r-1; signed, PIX_W+3 bits, no overflow.
REQ-023 mag = |gx| + |gy|, unsigned MAG_W bits, no overflow.
REQ-024 mode 0: out = all-ones if mag > threshold (strict), else 0.
REQ-025 mode 1: out = mag saturated to 2^PIX_W-1.
REQ-026 Output transfer on out_valid && out_ready; out_data held stable while out_valid && !out_ready; no drop or duplicate.
REQ-027 done asserted exactly in the cycle after the final output transfer (DONE state), for one cycle.
REQ-028 Input buffer contents are not cleared between frames; each frame fully overwrites them.

Reset
REQ-029 reset forces IDLE; in_ready, out_valid, out_data, busy, done all 0 next cycle.
REQ-030 reset mid-frame (any state) aborts the frame with no done pulse; next start begins a complete new frame.
REQ-031 reset has priority over start and all transfers in the same cycle.

Verification (IMG_W=IMG_H=5, PIX_W=8)
REQ-032 All 25 pixels = 100, mode 0, threshold 0 -> 25 outputs all 0; PROC lasts 25 cycles; done one pulse.
REQ-033 Columns 0-1 = 0, columns 2-4 = 255, mode 1 -> rows 1-3: col1 = 255, col2 = 255, col3 = 0; border 0 (mag = 1020 at cols 1-2).
REQ-034 Same frame, mode 0: threshold 1020 -> all 0; threshold 1019 -> rows 1-3 cols 1-2 = 255, rest 0.
REQ-035 out_ready toggled 1,0,1,0 and in_valid with random gaps -> identical 25-pixel stream, out_data stable during stalls.
REQ-036 reset asserted after 7 output transfers -> next cycle out_valid=0, busy=0, done=0; fresh start yields full correct frame.
REQ-037 start pulsed during LOAD and SEND -> ignored; exactly 25 in and 25 out transfers, one done.
